// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full-adder cell adds WIDTH-bit operands LSB first.
// Optional feature: define SERIAL_SUB_EN to add a `sub` input for a - b via two's complement.
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_sh_q, res_sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               fa_s, fa_cout;
  logic [WIDTH-1:0]   b_in_s;
  logic               cin_in_s;

  // Subtraction reuses the adder: a + ~b + 1.
`ifdef SERIAL_SUB_EN
  assign b_in_s   = sub ? ~b : b;
  assign cin_in_s = sub ? 1'b1 : cin;
`else
  assign b_in_s   = b;
  assign cin_in_s = cin;
`endif

  fa u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b_in_s;
          carry_d = cin_in_s;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        res_sh_d = {fa_s, res_sh_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          sum_d   = {fa_s, res_sh_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_RUN) || (state_d == S_DONE);
    done_d = (state_d == S_DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed table, multi-cycle corner sequences, random ops.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int total = 0;
  int passed = 0;
  logic [W-1:0] prev_sum = '0;
  logic         prev_cout = 1'b0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    bit           ghost;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // Reference: result of the whole op from plain arithmetic.
  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mcin, input logic msub);
    logic [W:0] r;
    if (msub) r = {1'b0, ma} + {1'b0, ~mb} + (W+1)'(1);
    else      r = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
    return r;
  endfunction

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                        input logic tsub, input logic [W-1:0] esum, input logic ecout,
                        input bit ghost, input string tag);
    int busy_cnt, done_cnt, done_at;
    bit held_ok;
    @(negedge clk);
    a = ta; b = tb; cin = tcin; sub = tsub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    busy_cnt = busy ? 1 : 0;
    done_cnt = 0;
    done_at  = 0;
    held_ok  = 1'b1;
    for (int i = 1; i <= W + 1; i++) begin
      if (ghost && i == 3) begin
        @(negedge clk);
        start = 1'b1; a = '1; b = '1; cin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_at = i; end
      if (i < W && (sum !== prev_sum || cout !== prev_cout)) held_ok = 1'b0;
      if (i == W + 1 && (sum !== esum || cout !== ecout)) held_ok = 1'b0;
      if (i == W) begin
        chk({tag, "_sum"}, 64'(sum), 64'(esum));
        chk({tag, "_cout"}, 64'(cout), 64'(ecout));
      end
      if (i == W + 1) chk({tag, "_busy_end"}, 64'(busy), 64'd0);
    end
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(W + 1));
    chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    chk({tag, "_done_latency"}, 64'(done_at), 64'(W));
    chk({tag, "_held"}, 64'(held_ok), 64'd1);
    prev_sum  = esum;
    prev_cout = ecout;
  endtask

  vec_t vecs[5];
  logic [W:0] r;
  logic [W-1:0] ra, rb;
  logic rc, rs;

  initial begin
    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0};
    vecs[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b1};

    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, vecs[i].sum, vecs[i].cout,
             vecs[i].ghost, $sformatf("vec%0d", i));

    // Reset in the middle of a run discards the partial result.
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_sum", 64'(sum), 64'd0);
    chk("midrst_cout", 64'(cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_sum = '0; prev_cout = 1'b0;
    run_op(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, "after_rst");

    // Start held high: back-to-back ops, second accepted on first IDLE edge.
    @(negedge clk);
    a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 8'h05; b = 8'h06; cin = 1'b1;
    repeat (W) @(posedge clk);
    #1;
    chk("held_done1", 64'(done), 64'd1);
    chk("held_sum1", 64'(sum), 64'h07);
    @(posedge clk); #1;
    chk("held_idle_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("held_accept_busy", 64'(busy), 64'd1);
    start = 1'b0;
    repeat (W) @(posedge clk);
    #1;
    chk("held_done2", 64'(done), 64'd1);
    chk("held_sum2", 64'(sum), 64'h0C);
    chk("held_cout2", 64'(cout), 64'd0);
    @(posedge clk); #1;
    prev_sum = 8'h0C; prev_cout = 1'b0;

`ifdef SERIAL_SUB_EN
    run_op(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0, "sub1");
    run_op(8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, "sub2");
`endif

    for (int n = 0; n < 30; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
`ifdef SERIAL_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      r = model(ra, rb, rc, rs);
      run_op(ra, rb, rc, rs, r[W-1:0], r[W], 1'($urandom_range(0, 3) == 0),
             $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
